// File: rtl/spram_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 16-bit words and writes them to SPRAM.
// Optional trailing checksum check is built when BOOT_CHECKSUM_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------
// S_HDR_LO  | waiting for word count low byte
// S_HDR_HI  | waiting for word count high byte, range check
// S_DATA_LO | waiting for data word low byte
// S_DATA_HI | waiting for data word high byte
// S_WRITE   | bus cycle in progress, waiting for bus_ack
// S_CSUM_LO | checksum low byte (checksum build only)
// S_CSUM_HI | checksum high byte, compare (checksum build only)
// S_DONE    | image loaded, CPU released
// S_ERROR   | load aborted, CPU stays held
module spram_boot_loader #(
    parameter int                ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [15:0]       bus_wrdata,
    output logic              bus_cyc,
    output logic              bus_write,
    input  logic              bus_ack,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [3:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_WRITE,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM_LO,
        S_CSUM_HI,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    // Where the stream goes once the last data word has been written.
`ifdef BOOT_CHECKSUM_EN
    localparam state_t END_STATE = S_CSUM_LO;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    // Largest count that fits between BASE_ADDR and the top of the address space.
    localparam int unsigned MAX_WORDS = (32'd1 << ADDR_W) - 32'(BASE_ADDR);

    state_t      state;
    logic [15:0] count;
    logic [15:0] words_done;
    logic [7:0]  lo_byte;
    logic        accept;
    logic [15:0] hdr_count;
    logic [15:0] words_next;
`ifdef BOOT_CHECKSUM_EN
    logic [15:0] csum;
    logic [7:0]  csum_lo;
`endif

    assign accept     = rx_valid && rx_ready;
    assign hdr_count  = {rx_data, count[7:0]};
    assign words_next = words_done + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_HDR_LO;
            rx_ready   <= 1'b0;
            bus_addr   <= BASE_ADDR;
            bus_wrdata <= '0;
            bus_cyc    <= 1'b0;
            bus_write  <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            count      <= '0;
            words_done <= '0;
            lo_byte    <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum       <= '0;
            csum_lo    <= '0;
`endif
        end else begin
            case (state)
                S_HDR_LO: begin
                    rx_ready <= 1'b1;
                    if (accept) begin
                        count[7:0] <= rx_data;
                        state      <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (accept) begin
                        count <= hdr_count;
                        if (hdr_count == 16'd0) begin
                            state    <= END_STATE;
                            rx_ready <= (END_STATE != S_DONE);
                            done     <= (END_STATE == S_DONE);
                            cpu_hold <= (END_STATE != S_DONE);
                        end else if (32'(hdr_count) > MAX_WORDS) begin
                            state    <= S_ERROR;
                            rx_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= S_DATA_LO;
                        end
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        lo_byte <= rx_data;
                        state   <= S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        bus_wrdata <= {rx_data, lo_byte};
                        bus_cyc    <= 1'b1;
                        bus_write  <= 1'b1;
                        rx_ready   <= 1'b0;
                        state      <= S_WRITE;
`ifdef BOOT_CHECKSUM_EN
                        csum       <= csum + {rx_data, lo_byte};
`endif
                    end
                end
                S_WRITE: begin
                    if (bus_ack) begin
                        bus_cyc    <= 1'b0;
                        bus_write  <= 1'b0;
                        bus_addr   <= bus_addr + ADDR_W'(1);
                        words_done <= words_next;
                        if (words_next == count) begin
                            state      <= END_STATE;
                            rx_ready   <= (END_STATE != S_DONE);
                            done       <= (END_STATE == S_DONE);
                            cpu_hold   <= (END_STATE != S_DONE);
                            bus_wrdata <= '0;
                        end else begin
                            state    <= S_DATA_LO;
                            rx_ready <= 1'b1;
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                S_CSUM_LO: begin
                    if (accept) begin
                        csum_lo <= rx_data;
                        state   <= S_CSUM_HI;
                    end
                end
                S_CSUM_HI: begin
                    if (accept) begin
                        rx_ready   <= 1'b0;
                        bus_wrdata <= '0;
                        if ({rx_data, csum_lo} == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    rx_ready  <= 1'b0;
                    bus_cyc   <= 1'b0;
                    bus_write <= 1'b0;
                    done      <= 1'b1;
                    cpu_hold  <= 1'b0;
                end
                S_ERROR: begin
                    rx_ready  <= 1'b0;
                    bus_cyc   <= 1'b0;
                    bus_write <= 1'b0;
                    error     <= 1'b1;
                    cpu_hold  <= 1'b1;
                end
                default: begin
                    state    <= S_ERROR;
                    rx_ready <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_boot_loader.sv
// Bench for spram_boot_loader: directed and randomized byte streams against a word-list model.
module tb_spram_boot_loader;
    localparam int MAXW = 16384;
    localparam int LOG  = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [13:0] bus_addr;
    logic [15:0] bus_wrdata;
    logic        bus_cyc;
    logic        bus_write;
    logic        bus_ack;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    int ack_delay = 0;
    int wait_cnt  = 0;
    int nwr = 0;
    logic [13:0] log_addr [LOG];
    logic [15:0] log_data [LOG];
    int cyc_cycles = 0;
    int viol = 0;
    int run_len = 0;
    int last_run = 0;
    logic        prev_cyc = 1'b0;
    logic [13:0] prev_addr = '0;
    logic [15:0] prev_data = '0;

    logic [15:0] words [$];

    spram_boot_loader dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_cyc(bus_cyc),
        .bus_write(bus_write), .bus_ack(bus_ack),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Slave acks after ack_delay extra cycles; delay 0 means ack follows cyc combinationally.
    assign bus_ack = bus_cyc && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (!bus_cyc || bus_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (rst && bus_cyc && bus_write && bus_ack) begin
            if (nwr < LOG) begin
                log_addr[nwr] <= bus_addr;
                log_data[nwr] <= bus_wrdata;
            end
            nwr <= nwr + 1;
        end
    end

    always @(negedge clk) begin
        if (bus_cyc) begin
            cyc_cycles = cyc_cycles + 1;
            run_len = run_len + 1;
            if (bus_write !== 1'b1 || rx_ready !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1)
                viol = viol + 1;
            if (prev_cyc && (bus_addr !== prev_addr || bus_wrdata !== prev_data))
                viol = viol + 1;
        end else begin
            if (bus_write !== 1'b0) viol = viol + 1;
            if (run_len != 0) begin
                last_run = run_len;
                run_len = 0;
            end
        end
        prev_cyc  = bus_cyc;
        prev_addr = bus_addr;
        prev_data = bus_wrdata;
    end

    task automatic do_reset();
        rst = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic gap(input int max_gap);
        int n;
        n = $urandom_range(max_gap, 0);
        if (n > 0) begin
            rx_valid = 1'b0;
            repeat (n) @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (rx_ready !== 1'b1) begin n_bad++; $error("FAIL rx_accept: observed %0h", rx_ready); end
        @(negedge clk);
    endtask

    // Streams header + words (+ checksum) and checks the result against the word list.
    task automatic run_load(input int hdr, input int delay, input int max_gap, input bit bad_sum);
        int base_w, base_c, base_v, n_exp, g;
        bit ok;
        logic [15:0] sum, hv, w;
        hv = hdr[15:0];
        ack_delay = delay;
        base_w = nwr;
        base_c = cyc_cycles;
        base_v = viol;
        sum = '0;
        n_exp = (hdr <= MAXW) ? hdr : 0;
        ok = (hdr <= MAXW) && !bad_sum;
        send_byte(hv[7:0]);
        gap(max_gap);
        send_byte(hv[15:8]);
        for (int i = 0; i < n_exp; i++) begin
            w = words[i];
            sum = sum + w;
            gap(max_gap);
            send_byte(w[7:0]);
            gap(max_gap);
            send_byte(w[15:8]);
        end
`ifdef BOOT_CHECKSUM_EN
        if (hdr <= MAXW) begin
            if (bad_sum) sum = sum ^ 16'h0001;
            send_byte(sum[7:0]);
            send_byte(sum[15:8]);
        end
`endif
        rx_valid = 1'b0;
        g = 0;
        while (!(done === 1'b1 || error === 1'b1) && g < 50) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (done !== ok) begin n_bad++; $error("FAIL done: observed %0h expected %0h", done, ok); end
        n_cmp++;
        if (error !== !ok) begin n_bad++; $error("FAIL error: observed %0h expected %0h", error, !ok); end
        n_cmp++;
        if (cpu_hold !== !ok) begin n_bad++; $error("FAIL cpu_hold: observed %0h expected %0h", cpu_hold, !ok); end
        n_cmp++;
        if (rx_ready !== 1'b0) begin n_bad++; $error("FAIL rx_ready_end: observed %0h", rx_ready); end
        n_cmp++;
        if (bus_cyc !== 1'b0) begin n_bad++; $error("FAIL bus_cyc_end: observed %0h", bus_cyc); end
        n_cmp++;
        if (nwr - base_w != n_exp) begin n_bad++; $error("FAIL write_count: observed %0d expected %0d", nwr - base_w, n_exp); end
        n_cmp++;
        if (cyc_cycles - base_c != n_exp * (delay + 1)) begin
            n_bad++; $error("FAIL cyc_cycles: observed %0d expected %0d", cyc_cycles - base_c, n_exp * (delay + 1));
        end
        n_cmp++;
        if (viol - base_v != 0) begin n_bad++; $error("FAIL bus_protocol: %0d violations", viol - base_v); end
        for (int i = 0; i < n_exp; i++) begin
            n_cmp++;
            if (log_addr[base_w + i] !== 14'(i)) begin
                n_bad++; $error("FAIL wr_addr: observed %0h expected %0h", log_addr[base_w + i], 14'(i));
            end
            n_cmp++;
            if (log_data[base_w + i] !== words[i]) begin
                n_bad++; $error("FAIL wr_data: observed %0h expected %0h", log_data[base_w + i], words[i]);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_w;
        rst = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rx_ready !== 1'b0) begin n_bad++; $error("FAIL rst_rx_ready: observed %0h", rx_ready); end
        n_cmp++;
        if (bus_cyc !== 1'b0) begin n_bad++; $error("FAIL rst_cyc: observed %0h", bus_cyc); end
        n_cmp++;
        if (bus_write !== 1'b0) begin n_bad++; $error("FAIL rst_write: observed %0h", bus_write); end
        n_cmp++;
        if (bus_addr !== 14'h0000) begin n_bad++; $error("FAIL rst_addr: observed %0h", bus_addr); end
        n_cmp++;
        if (bus_wrdata !== 16'h0000) begin n_bad++; $error("FAIL rst_wrdata: observed %0h", bus_wrdata); end
        n_cmp++;
        if (cpu_hold !== 1'b1) begin n_bad++; $error("FAIL rst_hold: observed %0h", cpu_hold); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $error("FAIL rst_done: observed %0h", done); end
        n_cmp++;
        if (error !== 1'b0) begin n_bad++; $error("FAIL rst_error: observed %0h", error); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rx_ready !== 1'b1) begin n_bad++; $error("FAIL ready_after_rst: observed %0h", rx_ready); end

        // Reference image, single-cycle acks.
        words = '{16'h1234, 16'h5678, 16'h9ABC};
        run_load(3, 0, 0, 1'b0);
        n_cmp++;
        if (last_run != 1) begin n_bad++; $error("FAIL single_cycle_write: observed %0d", last_run); end

        // Empty image.
        do_reset();
        words = {};
        run_load(0, 0, 0, 1'b0);

        // Slow slave with source holding rx_valid high.
        do_reset();
        words = {};
        for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
        run_load(3, 3, 0, 1'b0);
        n_cmp++;
        if (last_run != 4) begin n_bad++; $error("FAIL slow_write_len: observed %0d", last_run); end

        // Count one past the address space, and a far oversized count.
        do_reset();
        run_load(16385, 0, 0, 1'b0);
        do_reset();
        run_load(16'hFFFF, 0, 0, 1'b0);

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        words = '{16'h0001, 16'h0002};
        run_load(2, 0, 0, 1'b0);
        do_reset();
        run_load(2, 0, 0, 1'b1);
`endif

        // Reset during the second write, then a full reload from the base address.
        do_reset();
        ack_delay = 3;
        base_w = nwr;
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        n_cmp++;
        if (bus_cyc !== 1'b1) begin n_bad++; $error("FAIL mid_cyc_active: observed %0h", bus_cyc); end
        n_cmp++;
        if (bus_addr !== 14'h0001) begin n_bad++; $error("FAIL mid_addr: observed %0h", bus_addr); end
        rst = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus_cyc !== 1'b0) begin n_bad++; $error("FAIL mid_cyc_dropped: observed %0h", bus_cyc); end
        n_cmp++;
        if (nwr - base_w != 1) begin n_bad++; $error("FAIL mid_writes: observed %0d", nwr - base_w); end
        n_cmp++;
        if (cpu_hold !== 1'b1) begin n_bad++; $error("FAIL mid_hold: observed %0h", cpu_hold); end
        rst = 1'b1;
        @(negedge clk);
        words = {};
        for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
        run_load(3, 0, 0, 1'b0);

        // Randomized images, slave latencies and byte gaps.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            n = $urandom_range(12, 1);
            words = {};
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            run_load(n, $urandom_range(3, 0), 3, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
